// File: rtl/quote_scheduler.sv
// Coalescing round-robin scheduler for a shared trading_logic datapath.
// Keeps one in-flight request per stock and tags results through an in-order FIFO.
module quote_scheduler #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FP_WORD_SIZE = 64,
    parameter int unsigned NUM_STOCKS   = 4,
    parameter int unsigned MAX_INFLIGHT = 4,
    localparam int unsigned SID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_flush,
    input  logic                    i_md_valid,
    input  logic [SID_W-1:0]        i_md_stock_id,
    input  logic [DATA_WIDTH-1:0]   i_md_best_ask,
    input  logic [DATA_WIDTH-1:0]   i_md_best_bid,
    input  logic [FP_WORD_SIZE-1:0] i_md_inventory,
    input  logic [FP_WORD_SIZE-1:0] i_md_curr_time,
    input  logic                    i_tl_ready,
    output logic                    o_tl_valid,
    output logic [SID_W-1:0]        o_tl_stock_id,
    output logic [DATA_WIDTH-1:0]   o_tl_best_ask,
    output logic [DATA_WIDTH-1:0]   o_tl_best_bid,
    output logic [FP_WORD_SIZE-1:0] o_tl_inventory,
    output logic [FP_WORD_SIZE-1:0] o_tl_curr_time,
    input  logic                    i_tl_result_valid,
    input  logic [DATA_WIDTH-1:0]   i_tl_buy_price,
    input  logic [DATA_WIDTH-1:0]   i_tl_sell_price,
    output logic                    o_quote_valid,
    output logic [SID_W-1:0]        o_quote_stock_id,
    output logic [DATA_WIDTH-1:0]   o_buy_price,
    output logic [DATA_WIDTH-1:0]   o_sell_price,
    output logic [CNT_W-1:0]        o_inflight,
    output logic [15:0]             o_drop_count,
    output logic                    o_err_underflow
);

    localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   slot_ask_q  [NUM_STOCKS];
    logic [DATA_WIDTH-1:0]   slot_bid_q  [NUM_STOCKS];
    logic [FP_WORD_SIZE-1:0] slot_inv_q  [NUM_STOCKS];
    logic [FP_WORD_SIZE-1:0] slot_time_q [NUM_STOCKS];
    logic [NUM_STOCKS-1:0]   pending_q, pending_d, busy_q, busy_d, eligible;
    logic [SID_W-1:0]        fifo_q [MAX_INFLIGHT];
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [SID_W-1:0]        rr_ptr_q, grant_id, idx_sid;
    logic [15:0]             drop_q;
    logic                    grant_found, issue, pop, drop_event;
    int                      idx;

    // Round-robin search: the smallest offset from rr_ptr+1 wins, so scan downwards.
    always_comb begin
        eligible    = pending_q & ~busy_q;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        idx_sid     = '0;
        for (int k = int'(NUM_STOCKS); k >= 1; k--) begin
            idx     = (int'(rr_ptr_q) + k) % int'(NUM_STOCKS);
            idx_sid = SID_W'(idx);
            if (eligible[idx_sid]) begin
                grant_found = 1'b1;
                grant_id    = idx_sid;
            end
        end
    end

    always_comb begin
        issue = (state_q == StRun) && !i_flush && i_tl_ready &&
                (count_q < CNT_W'(MAX_INFLIGHT)) && grant_found;
        pop   = i_tl_result_valid && (count_q != '0);
        drop_event = i_md_valid && pending_q[i_md_stock_id] &&
                     !(issue && (grant_id == i_md_stock_id));

        pending_d = pending_q;
        if (issue) pending_d[grant_id] = 1'b0;
        if (i_flush) pending_d = '0;
        // A capture during flush/drain still lands in its slot and stays pending.
        if (i_md_valid) pending_d[i_md_stock_id] = 1'b1;

        busy_d = busy_q;
        if (pop) busy_d[fifo_q[rd_ptr_q]] = 1'b0;
        if (issue) busy_d[grant_id] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (i_enable) state_d = StRun;
            StRun:   if (!i_enable) state_d = StIdle;
            StDrain: if (count_q == '0) state_d = i_enable ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
        if (i_flush) state_d = StDrain;
    end

    always_ff @(posedge i_clk) begin
        if (i_md_valid) begin
            slot_ask_q[i_md_stock_id]  <= i_md_best_ask;
            slot_bid_q[i_md_stock_id]  <= i_md_best_bid;
            slot_inv_q[i_md_stock_id]  <= i_md_inventory;
            slot_time_q[i_md_stock_id] <= i_md_curr_time;
        end
        if (issue) fifo_q[wr_ptr_q] <= grant_id;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q          <= StIdle;
            pending_q        <= '0;
            busy_q           <= '0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            rr_ptr_q         <= SID_W'(NUM_STOCKS - 1);
            drop_q           <= '0;
            o_err_underflow  <= 1'b0;
            o_tl_valid       <= 1'b0;
            o_tl_stock_id    <= '0;
            o_tl_best_ask    <= '0;
            o_tl_best_bid    <= '0;
            o_tl_inventory   <= '0;
            o_tl_curr_time   <= '0;
            o_quote_valid    <= 1'b0;
            o_quote_stock_id <= '0;
            o_buy_price      <= '0;
            o_sell_price     <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            count_q    <= count_q + CNT_W'(issue) - CNT_W'(pop);
            o_tl_valid <= issue;
            if (issue) begin
                o_tl_stock_id  <= grant_id;
                o_tl_best_ask  <= slot_ask_q[grant_id];
                o_tl_best_bid  <= slot_bid_q[grant_id];
                o_tl_inventory <= slot_inv_q[grant_id];
                o_tl_curr_time <= slot_time_q[grant_id];
                rr_ptr_q       <= grant_id;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            o_quote_valid <= pop;
            if (pop) begin
                o_quote_stock_id <= fifo_q[rd_ptr_q];
                o_buy_price      <= i_tl_buy_price;
                o_sell_price     <= i_tl_sell_price;
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (i_tl_result_valid && (count_q == '0)) o_err_underflow <= 1'b1;
            if (drop_event && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
        end
    end

    assign o_inflight   = count_q;
    assign o_drop_count = drop_q;

endmodule
